lc3_memsys: RTL and testbench
=============================

LC3_MEMSYS -- requirements
Module: lc3_memsys

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 16, meaning the width of the pc and Data_addr ports.
REQ-002 The block SHALL have parameter DATA_W, default 16, meaning the memory word width.
REQ-003 The block SHALL have parameter DEPTH_LOG2, default 8, meaning the log2 of the number of words in the unified instruction/data array.
REQ-004 The block SHALL have parameter INSTR_LAT, default 0, range 0..7, meaning the extra wait cycles on the instruction port.
REQ-005 The block SHALL have parameter DATA_LAT, default 2, range 0..7, meaning the extra wait cycles on the data port.
REQ-006 clk  input  1  sole clock; all state on rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 pc  input  ADDR_W  instruction fetch address.
REQ-009 instrmem_rd  input  1  fetch request; held high by requester until complete_instr.
REQ-010 Instr_dout  output  DATA_W  fetched word.
REQ-011 complete_instr  output  1  one-cycle fetch completion pulse.
REQ-012 Data_addr  input  ADDR_W  data access address.
REQ-013 Data_en  input  1  data request; held high until complete_data.
REQ-014 Data_rd  input  1  access direction: 1 = read, 0 = write.
REQ-015 Data_din  input  DATA_W  write data.
REQ-016 Data_dout  output  DATA_W  read data.
REQ-017 complete_data  output  1  one-cycle data completion pulse.
REQ-018 load_en, load_addr[ADDR_W], load_data[DATA_W]  input  bench back-door preload, one word per cycle.
REQ-019 instr_cnt, data_cnt  output  16  completed-access counters.

Function
REQ-020 Each port (instr, data) SHALL run an independent FSM with states IDLE, WAIT, DONE.
REQ-021 IDLE->WAIT SHALL occur when the request is high, capturing address, direction and write data, and loading the wait counter with the port LAT.
REQ-022 WAIT SHALL decrement the counter and go to DONE when the counter is 0, so completion occurs exactly LAT+1 cycles after the request is sampled.
REQ-023 DONE SHALL assert the completion pulse for one cycle, perform the array access, and return to IDLE unconditionally; a still-high request SHALL be re-sampled in IDLE, giving a minimum of LAT+2 cycles per access.
REQ-024 Request changes during WAIT/DONE SHALL be ignored; the captured values SHALL be used.
REQ-025 Addresses SHALL wrap: only the low DEPTH_LOG2 bits index the array; upper bits are ignored.
REQ-026 A read SHALL update Instr_dout/Data_dout in the DONE cycle; outputs SHALL hold their value until the next read completion, and a write SHALL leave Data_dout unchanged.
REQ-027 A data write and an instruction read completing in the same cycle to the same word: the read SHALL return the pre-write value.
REQ-028 A load_en write and a data write to the same word in the same cycle: the data write SHALL win.
REQ-029 The counters SHALL increment on each completion pulse and saturate at 16'hFFFF.

Reset
REQ-030 Reset low SHALL immediately force both FSMs to IDLE and drive Instr_dout, Data_dout, complete_instr, complete_data, instr_cnt and data_cnt to 0.
REQ-031 The array contents SHALL NOT be reset.
REQ-032 A write in WAIT when reset asserts SHALL be aborted and not committed; no completion SHALL pulse for it.

Structure
REQ-033 Package lc3_mem_pkg SHALL hold the port-state enum, the LAT_W=3 constant and the counter width.
REQ-034 Sub-module lc3_mem_port_fsm (FSM, wait counter, capture registers, access counter) SHALL be instantiated once per port.

Verification
REQ-035 Preload addr 16'h3000=16'h1234 via load_en, fetch pc=16'h3000, INSTR_LAT=0 -> complete_instr 1 cycle after sampling, Instr_dout=16'h1234, instr_cnt=1.
REQ-036 DATA_LAT=2, write 16'hBEEF to 16'h0010, then read 16'h0010 -> each complete_data exactly 3 cycles after sampling, Data_dout=16'hBEEF.
REQ-037 DEPTH_LOG2=8, write 16'hAAAA to 16'h0105, read 16'h0005 -> returns 16'hAAAA.
REQ-038 Word 16'h0020 holds 16'h0001; data write 16'h0002 and fetch of 16'h0020 complete in the same cycle -> Instr_dout=16'h0001; a following fetch returns 16'h0002.
REQ-039 Drop reset one cycle into a DATA_LAT=2 write of 16'h5555 to 16'h0040 (old value 16'h0000) -> no complete_data, all outputs 0, a subsequent read returns 16'h0000.
REQ-040 Hold both requests high continuously for 10 accesses each, INSTR_LAT=0, DATA_LAT=2 -> complete_instr every 2 cycles, complete_data every 4 cycles, both counters=10.

Source files
------------

// File: rtl/lc3_mem_pkg.sv
// rtl/lc3_mem_pkg.sv - shared types and widths for the LC-3 unified memory system
package lc3_mem_pkg;

  localparam int LAT_W = 3;
  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } port_state_e;

endpackage

// File: rtl/lc3_mem_port_fsm.sv
// rtl/lc3_mem_port_fsm.sv - per-port request FSM with wait counter, capture registers and access counter
module lc3_mem_port_fsm
  import lc3_mem_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int LAT    = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic [ADDR_W-1:0] addr,
  input  logic              rd,
  input  logic [DATA_W-1:0] wdata,
  output logic              access,
  output logic [ADDR_W-1:0] access_addr,
  output logic              access_rd,
  output logic [DATA_W-1:0] access_wdata,
  output logic              complete,
  output logic [CNT_W-1:0]  cnt
);

  // WAIT lasts LAT cycles, so DONE lands LAT+1 edges after sampling and back-to-back
  // accesses repeat every LAT+2 cycles; LAT=0 goes straight from IDLE to DONE.
  localparam logic [LAT_W-1:0] LAT_M1 = LAT_W'((LAT > 0) ? LAT - 1 : 0);

  port_state_e       state, state_next;
  logic [LAT_W-1:0]  wait_cnt, wait_cnt_next;
  logic              enter_done;
  logic [ADDR_W-1:0] cap_addr;
  logic              cap_rd;
  logic [DATA_W-1:0] cap_wdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      wait_cnt  <= '0;
      cap_addr  <= '0;
      cap_rd    <= 1'b1;
      cap_wdata <= '0;
      cnt       <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
      if (state == ST_IDLE && req) begin
        cap_addr  <= addr;
        cap_rd    <= rd;
        cap_wdata <= wdata;
      end
      if (complete && cnt != {CNT_W{1'b1}}) cnt <= cnt + CNT_W'(1);
    end
  end

  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    enter_done    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req) begin
          if (LAT == 0) begin
            state_next = ST_DONE;
            enter_done = 1'b1;
          end else begin
            state_next    = ST_WAIT;
            wait_cnt_next = LAT_M1;
          end
        end
      end
      ST_WAIT: begin
        if (wait_cnt == '0) begin
          state_next = ST_DONE;
          enter_done = 1'b1;
        end else begin
          wait_cnt_next = wait_cnt - LAT_W'(1);
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // The array is touched on the edge entering DONE so read data and the pulse coincide.
  assign access       = enter_done & reset;
  assign access_addr  = (state == ST_IDLE) ? addr  : cap_addr;
  assign access_rd    = (state == ST_IDLE) ? rd    : cap_rd;
  assign access_wdata = (state == ST_IDLE) ? wdata : cap_wdata;
  assign complete     = (state == ST_DONE);

endmodule

// File: rtl/lc3_memsys.sv
// rtl/lc3_memsys.sv - unified LC-3 instruction/data memory with independent latency-modelled ports
module lc3_memsys
  import lc3_mem_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int DEPTH_LOG2 = 8,
  parameter int INSTR_LAT  = 0,
  parameter int DATA_LAT   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc,
  input  logic              instrmem_rd,
  output logic [DATA_W-1:0] Instr_dout,
  output logic              complete_instr,
  input  logic [ADDR_W-1:0] Data_addr,
  input  logic              Data_en,
  input  logic              Data_rd,
  input  logic [DATA_W-1:0] Data_din,
  output logic [DATA_W-1:0] Data_dout,
  output logic              complete_data,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic [CNT_W-1:0]  instr_cnt,
  output logic [CNT_W-1:0]  data_cnt
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [DATA_W-1:0]     mem [DEPTH];
  logic                  i_access, i_rd, d_access, d_rd;
  logic [DEPTH_LOG2-1:0] i_idx, d_idx;
  logic [DATA_W-1:0]     i_wdata, d_wdata;
  logic                  unused_bits;

  lc3_mem_port_fsm #(.ADDR_W(DEPTH_LOG2), .DATA_W(DATA_W), .LAT(INSTR_LAT)) u_instr (
    .clk(clk), .reset(reset), .req(instrmem_rd), .addr(pc[DEPTH_LOG2-1:0]),
    .rd(1'b1), .wdata({DATA_W{1'b0}}), .access(i_access), .access_addr(i_idx),
    .access_rd(i_rd), .access_wdata(i_wdata), .complete(complete_instr), .cnt(instr_cnt)
  );

  lc3_mem_port_fsm #(.ADDR_W(DEPTH_LOG2), .DATA_W(DATA_W), .LAT(DATA_LAT)) u_data (
    .clk(clk), .reset(reset), .req(Data_en), .addr(Data_addr[DEPTH_LOG2-1:0]),
    .rd(Data_rd), .wdata(Data_din), .access(d_access), .access_addr(d_idx),
    .access_rd(d_rd), .access_wdata(d_wdata), .complete(complete_data), .cnt(data_cnt)
  );

  // Upper address bits wrap away; the instruction port is wired read-only.
  assign unused_bits = ^{pc[ADDR_W-1:DEPTH_LOG2], Data_addr[ADDR_W-1:DEPTH_LOG2],
                         load_addr[ADDR_W-1:DEPTH_LOG2], i_rd, i_wdata};

  // Data write is last so it wins over a same-word preload.
  always_ff @(posedge clk) begin
    if (load_en) mem[load_addr[DEPTH_LOG2-1:0]] <= load_data;
    if (d_access && !d_rd) mem[d_idx] <= d_wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Instr_dout <= '0;
      Data_dout  <= '0;
    end else begin
      if (i_access) Instr_dout <= mem[i_idx];
      if (d_access && d_rd) Data_dout <= mem[d_idx];
    end
  end

endmodule

// File: tb/tb_lc3_memsys.sv
// tb/tb_lc3_memsys.sv - directed self-checking bench for lc3_memsys
module tb_lc3_memsys;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] pc;
  logic        instrmem_rd;
  logic [15:0] Instr_dout;
  logic        complete_instr;
  logic [15:0] Data_addr;
  logic        Data_en;
  logic        Data_rd;
  logic [15:0] Data_din;
  logic [15:0] Data_dout;
  logic        complete_data;
  logic        load_en;
  logic [15:0] load_addr;
  logic [15:0] load_data;
  logic [15:0] instr_cnt;
  logic [15:0] data_cnt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lc3_memsys #(.ADDR_W(16), .DATA_W(16), .DEPTH_LOG2(8), .INSTR_LAT(0), .DATA_LAT(2)) dut (
    .clk(clk), .reset(reset), .pc(pc), .instrmem_rd(instrmem_rd), .Instr_dout(Instr_dout),
    .complete_instr(complete_instr), .Data_addr(Data_addr), .Data_en(Data_en),
    .Data_rd(Data_rd), .Data_din(Data_din), .Data_dout(Data_dout),
    .complete_data(complete_data), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .instr_cnt(instr_cnt), .data_cnt(data_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load_word(input logic [15:0] a, input logic [15:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    @(posedge clk); #1;
    load_en = 1'b0;
  endtask

  // Latency counts rising edges from raising the request until the pulse is seen.
  task automatic fetch(input logic [15:0] a, output int lat, output int t_done);
    pc = a; instrmem_rd = 1'b1; lat = -1; t_done = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (complete_instr) begin
        lat = c; t_done = int'($time); instrmem_rd = 1'b0;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic data_op(input logic [15:0] a, input logic r, input logic [15:0] wd,
                         output int lat, output int t_done);
    Data_addr = a; Data_rd = r; Data_din = wd; Data_en = 1'b1; lat = -1; t_done = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (complete_data) begin
        lat = c; t_done = int'($time); Data_en = 1'b0;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int lat_a, lat_b, t_a, t_b, seen, ic, dc, li, ld;
    reset = 1'b1; pc = '0; instrmem_rd = 1'b0; Data_addr = '0; Data_en = 1'b0;
    Data_rd = 1'b0; Data_din = '0; load_en = 1'b0; load_addr = '0; load_data = '0;
    #2 reset = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk("rst_instr_dout", Instr_dout, 16'h0);
    chk("rst_data_dout", Data_dout, 16'h0);
    chk("rst_complete", {complete_instr, complete_data}, 2'b00);
    chk("rst_instr_cnt", instr_cnt, 16'h0);
    chk("rst_data_cnt", data_cnt, 16'h0);
    reset = 1'b1;
    @(posedge clk); #1;

    load_word(16'h3000, 16'h1234);
    load_word(16'h0020, 16'h0001);
    load_word(16'h0040, 16'h0000);

    fetch(16'h3000, lat_a, t_a);
    chk("fetch_lat", lat_a, 1);
    chk("fetch_data", Instr_dout, 16'h1234);
    chk("fetch_cnt", instr_cnt, 1);

    data_op(16'h0010, 1'b0, 16'hBEEF, lat_a, t_a);
    chk("wr_lat", lat_a, 3);
    chk("wr_keeps_dout", Data_dout, 16'h0);
    data_op(16'h0010, 1'b1, 16'h0, lat_a, t_a);
    chk("rd_lat", lat_a, 3);
    chk("rd_data", Data_dout, 16'hBEEF);
    chk("data_cnt_2", data_cnt, 2);

    data_op(16'h0105, 1'b0, 16'hAAAA, lat_a, t_a);
    data_op(16'h0005, 1'b1, 16'h0, lat_a, t_a);
    chk("wrap_data", Data_dout, 16'hAAAA);

    // Data write (LAT 2) and fetch (LAT 0) of word 0x20 finish on the same edge.
    fork
      data_op(16'h0020, 1'b0, 16'h0002, lat_a, t_a);
      begin
        repeat (2) @(posedge clk); #1;
        fetch(16'h0020, lat_b, t_b);
      end
    join
    chk("same_cycle_done", t_b, t_a);
    chk("pre_write_read", Instr_dout, 16'h0001);
    fetch(16'h0020, lat_b, t_b);
    chk("post_write_read", Instr_dout, 16'h0002);

    fork
      data_op(16'h0050, 1'b0, 16'h2222, lat_a, t_a);
      begin
        repeat (2) @(posedge clk); #1;
        load_word(16'h0050, 16'h1111);
      end
    join
    data_op(16'h0050, 1'b1, 16'h0, lat_a, t_a);
    chk("write_beats_load", Data_dout, 16'h2222);

    Data_addr = 16'h0040; Data_rd = 1'b0; Data_din = 16'h5555; Data_en = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; Data_en = 1'b0;
    #1;
    chk("abort_instr_dout", Instr_dout, 16'h0);
    chk("abort_data_dout", Data_dout, 16'h0);
    chk("abort_instr_cnt", instr_cnt, 16'h0);
    chk("abort_data_cnt", data_cnt, 16'h0);
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (complete_data) seen++;
    end
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (complete_data) seen++;
    end
    chk("abort_no_complete", seen, 0);
    data_op(16'h0040, 1'b1, 16'h0, lat_a, t_a);
    chk("abort_rd_lat", lat_a, 3);
    chk("abort_not_written", Data_dout, 16'h0000);

    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    pc = 16'h3000; instrmem_rd = 1'b1;
    Data_addr = 16'h0010; Data_rd = 1'b1; Data_en = 1'b1;
    ic = 0; dc = 0; li = 0; ld = 0;
    for (int cyc = 1; cyc <= 80 && (ic < 10 || dc < 10); cyc++) begin
      @(posedge clk); #1;
      if (complete_instr) begin
        if (ic == 0) chk("burst_instr_first", cyc, 1);
        else         chk("burst_instr_gap", cyc - li, 2);
        li = cyc; ic++;
        if (ic == 10) instrmem_rd = 1'b0;
      end
      if (complete_data) begin
        if (dc == 0) chk("burst_data_first", cyc, 3);
        else         chk("burst_data_gap", cyc - ld, 4);
        ld = cyc; dc++;
        if (dc == 10) Data_en = 1'b0;
      end
    end
    repeat (6) @(posedge clk); #1;
    chk("burst_instr_cnt", instr_cnt, 10);
    chk("burst_data_cnt", data_cnt, 10);
    chk("burst_instr_dout", Instr_dout, 16'h1234);
    chk("burst_data_dout", Data_dout, 16'hBEEF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
